// File: rtl/branch_history_table.sv
// Gshare direction predictor: PC xor global history indexes 2-bit saturating
// counters; resolved branches train the counters and repair speculative history.
module branch_history_table #(
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned GHR_WIDTH   = 6,
  parameter int unsigned PC_WIDTH    = 32,
  parameter logic [1:0]  INIT_STATE  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pred_valid,
  input  logic [PC_WIDTH-1:0]  pred_pc,
  output logic                 pred_taken,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  input  logic                 upd_valid,
  input  logic [PC_WIDTH-1:0]  upd_pc,
  input  logic [GHR_WIDTH-1:0] upd_ghr,
  input  logic                 upd_pred,
  input  logic                 upd_taken,
  output logic                 mispredict,
  output logic [GHR_WIDTH-1:0] ghr
);

  localparam int unsigned ENTRIES = 1 << INDEX_WIDTH;

  logic [1:0]             cnt_q [ENTRIES];
  logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;
  logic                   mispredict_q, mispredict_d;
  logic [INDEX_WIDTH-1:0] pred_idx, upd_idx;
  logic [1:0]             upd_cnt, upd_cnt_d;

  // PC bits below the word offset and above the index never reach the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:INDEX_WIDTH+2], pred_pc[1:0],
                            upd_pc[PC_WIDTH-1:INDEX_WIDTH+2], upd_pc[1:0]};

  assign pred_idx = pred_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_q);
  assign upd_idx  = upd_pc[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(upd_ghr);

  // Prediction reads the pre-update counter; no same-cycle bypass.
  assign pred_taken = cnt_q[pred_idx][1];
  assign pred_ghr   = ghr_q;
  assign ghr        = ghr_q;
  assign mispredict = mispredict_q;

  // Saturating train of the resolved entry.
  always_comb begin
    upd_cnt   = cnt_q[upd_idx];
    upd_cnt_d = upd_cnt;
    if (upd_taken) begin
      if (upd_cnt != 2'b11) upd_cnt_d = upd_cnt + 2'd1;
    end else begin
      if (upd_cnt != 2'b00) upd_cnt_d = upd_cnt - 2'd1;
    end
  end

  // Repair from the resolved snapshot outranks a speculative shift.
  always_comb begin
    ghr_d        = ghr_q;
    mispredict_d = upd_valid && (upd_pred != upd_taken);
    if (mispredict_d) begin
      ghr_d = GHR_WIDTH'({upd_ghr, upd_taken});
    end else if (pred_valid) begin
      ghr_d = GHR_WIDTH'({ghr_q, pred_taken});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= INIT_STATE;
      end
    end else if (upd_valid) begin
      cnt_q[upd_idx] <= upd_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q        <= '0;
      mispredict_q <= 1'b0;
    end else begin
      ghr_q        <= ghr_d;
      mispredict_q <= mispredict_d;
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// Directed vector bench for the gshare branch history table.
module tb_branch_history_table;

  logic        clk;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [5:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [5:0]  upd_ghr;
  logic        upd_pred;
  logic        upd_taken;
  logic        mispredict;
  logic [5:0]  ghr;

  int checks = 0;
  int errors = 0;

  branch_history_table #(
    .INDEX_WIDTH(6),
    .GHR_WIDTH  (6),
    .PC_WIDTH   (32),
    .INIT_STATE (2'b01)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pred_valid(pred_valid),
    .pred_pc   (pred_pc),
    .pred_taken(pred_taken),
    .pred_ghr  (pred_ghr),
    .upd_valid (upd_valid),
    .upd_pc    (upd_pc),
    .upd_ghr   (upd_ghr),
    .upd_pred  (upd_pred),
    .upd_taken (upd_taken),
    .mispredict(mispredict),
    .ghr       (ghr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] ppc;
    logic        uv;
    logic [31:0] upc;
    logic [5:0]  ughr;
    logic        up;
    logic        ut;
    logic        exp_pt;    // pred_taken before the edge
    logic [5:0]  exp_pghr;  // pred_ghr before the edge
    logic [5:0]  exp_ghr;   // ghr after the edge
    logic        exp_mp;    // mispredict after the edge
  } vec_t;

  vec_t tbl [18];
  vec_t seq [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    pred_valid = v.pv;
    pred_pc    = v.ppc;
    upd_valid  = v.uv;
    upd_pc     = v.upc;
    upd_ghr    = v.ughr;
    upd_pred   = v.up;
    upd_taken  = v.ut;
    #1;
    chk({tag, " pred_taken"}, 32'(pred_taken), 32'(v.exp_pt));
    chk({tag, " pred_ghr"}, 32'(pred_ghr), 32'(v.exp_pghr));
    @(posedge clk);
    #1;
    chk({tag, " ghr"}, 32'(ghr), 32'(v.exp_ghr));
    chk({tag, " mispredict"}, 32'(mispredict), 32'(v.exp_mp));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst        = 1'b1;
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
    #1;
    chk({tag, " rst pred_taken"}, 32'(pred_taken), 32'd0);
    chk({tag, " rst pred_ghr"}, 32'(pred_ghr), 32'd0);
    chk({tag, " rst ghr"}, 32'(ghr), 32'd0);
    chk({tag, " rst mispredict"}, 32'(mispredict), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //           pv   ppc         uv   upc         ughr       up   ut   pt   pghr       ghr        mp
    // Saturation at entry 0 with GHR held at 0
    tbl[0]  = '{1'b0, 32'h100, 1'b1, 32'h100, 6'h00, 1'b1, 1'b1, 1'b0, 6'h00, 6'h00, 1'b0};
    tbl[1]  = '{1'b0, 32'h100, 1'b1, 32'h100, 6'h00, 1'b1, 1'b1, 1'b1, 6'h00, 6'h00, 1'b0};
    tbl[2]  = '{1'b0, 32'h100, 1'b1, 32'h100, 6'h00, 1'b1, 1'b1, 1'b1, 6'h00, 6'h00, 1'b0};
    tbl[3]  = '{1'b0, 32'h100, 1'b1, 32'h100, 6'h00, 1'b1, 1'b1, 1'b1, 6'h00, 6'h00, 1'b0};
    tbl[4]  = '{1'b0, 32'h100, 1'b1, 32'h100, 6'h00, 1'b0, 1'b0, 1'b1, 6'h00, 6'h00, 1'b0};
    tbl[5]  = '{1'b0, 32'h100, 1'b1, 32'h100, 6'h00, 1'b0, 1'b0, 1'b1, 6'h00, 6'h00, 1'b0};
    tbl[6]  = '{1'b0, 32'h100, 1'b1, 32'h100, 6'h00, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0};
    tbl[7]  = '{1'b0, 32'h100, 1'b1, 32'h100, 6'h00, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0};
    // Mispredicted update at the floor: counter stays 00, flag for one cycle
    tbl[8]  = '{1'b0, 32'h100, 1'b1, 32'h100, 6'h00, 1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 1'b1};
    tbl[9]  = '{1'b0, 32'h100, 1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0};
    // Speculative shift of not-taken predictions, then train entry 4 and shift a 1
    tbl[10] = '{1'b1, 32'h010, 1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0};
    tbl[11] = '{1'b1, 32'h010, 1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0};
    tbl[12] = '{1'b1, 32'h010, 1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0};
    tbl[13] = '{1'b0, 32'h010, 1'b1, 32'h010, 6'h00, 1'b1, 1'b1, 1'b0, 6'h00, 6'h00, 1'b0};
    tbl[14] = '{1'b1, 32'h010, 1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b1, 6'h00, 6'h01, 1'b0};
    tbl[15] = '{1'b0, 32'h010, 1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 6'h01, 6'h01, 1'b0};
    // Repair outranks a same-cycle prediction
    tbl[16] = '{1'b1, 32'h010, 1'b1, 32'h200, 6'h2a, 1'b0, 1'b1, 1'b0, 6'h01, 6'h15, 1'b1};
    tbl[17] = '{1'b0, 32'h010, 1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 6'h15, 6'h15, 1'b0};

    // Aliasing: pc 0x104/ghr 0 and pc 0x100/ghr 1 share entry 1
    seq[0] = '{1'b0, 32'h100, 1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, 1'b0};
    seq[1] = '{1'b0, 32'h100, 1'b1, 32'h008, 6'h00, 1'b0, 1'b1, 1'b0, 6'h00, 6'h01, 1'b1};
    seq[2] = '{1'b0, 32'h100, 1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b0, 6'h01, 6'h01, 1'b0};
    seq[3] = '{1'b0, 32'h100, 1'b1, 32'h104, 6'h00, 1'b1, 1'b1, 1'b0, 6'h01, 6'h01, 1'b0};
    seq[4] = '{1'b0, 32'h100, 1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b1, 6'h01, 6'h01, 1'b0};
    // Leave mispredict, ghr and pred_taken all non-zero ahead of the mid-stream reset
    seq[5] = '{1'b0, 32'h100, 1'b1, 32'h008, 6'h00, 1'b0, 1'b1, 1'b1, 6'h01, 6'h01, 1'b1};

    rst = 1'b1; pred_valid = 1'b0; pred_pc = '0; upd_valid = 1'b0;
    upd_pc = '0; upd_ghr = '0; upd_pred = 1'b0; upd_taken = 1'b0;
    do_reset("init");

    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    do_reset("alias");
    for (int i = 0; i < 6; i++) apply(seq[i], $sformatf("seq[%0d]", i));

    // Asynchronous reset mid-stream, then every entry must predict not-taken
    do_reset("mid");
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pred_pc = 32'(i) << 2;
      #1;
      chk($sformatf("post-rst entry %0d", i), 32'(pred_taken), 32'd0);
    end

    // Same-cycle predict and update to entry 8: old value seen, new value next cycle
    apply('{1'b1, 32'h020, 1'b1, 32'h020, 6'h00, 1'b1, 1'b1, 1'b0, 6'h00, 6'h00, 1'b0}, "same-idx");
    apply('{1'b0, 32'h020, 1'b0, 32'h000, 6'h00, 1'b0, 1'b0, 1'b1, 6'h00, 6'h00, 1'b0}, "same-idx next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
